// File: rtl/config_loader.sv
// Sequencer that streams NUM_WORDS configuration words into the latch bank, one one-hot enable pulse per word.
// Latency: handshake -> data on io_d_out next cycle -> enable pulse one cycle later; 4 cycles per word minimum.
// Backpressure: io_in_ready only in ACCEPT (and CHECK); valid stalls stretch ACCEPT only. Optional macro: CONFIG_LOADER_CHECKSUM_EN.
module config_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 24,
   parameter int IDX_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_start,
   input  logic                  io_in_valid,
   output logic                  io_in_ready,
   input  logic [DATA_WIDTH-1:0] io_in_data,
   output logic [DATA_WIDTH-1:0] io_d_out,
   output logic [NUM_WORDS-1:0]  io_configs_en,
   output logic [IDX_WIDTH-1:0]  io_word_idx,
   output logic                  io_busy,
   output logic                  io_done,
   output logic                  io_error
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);
   localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCEPT = 3'd1,
      SETUP  = 3'd2,
      PULSE  = 3'd3,
      HOLD   = 3'd4,
`ifdef CONFIG_LOADER_CHECKSUM_EN
      CHECK  = 3'd5,
`endif
      DONE   = 3'd6
   } state_t;

   state_t state;

`ifdef CONFIG_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] xor_acc;
   logic                  error_q;
`endif

   // Sequencer: data bus, enables, index and done flag are all flops so the latch bank never sees a decode glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         io_word_idx   <= '0;
         io_d_out      <= '0;
         io_configs_en <= '0;
         io_done       <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
         xor_acc       <= '0;
         error_q       <= 1'b0;
`endif
      end else begin
         // Enables are high for exactly one cycle: only the SETUP branch sets them.
         io_configs_en <= '0;
         case (state)
            IDLE, DONE: begin
               if (io_start) begin
                  state       <= ACCEPT;
                  io_word_idx <= '0;
                  io_done     <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  xor_acc     <= '0;
                  error_q     <= 1'b0;
`endif
               end
            end
            ACCEPT: begin
               if (io_in_valid) begin
                  io_d_out <= io_in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  xor_acc  <= xor_acc ^ io_in_data;
`endif
                  state    <= SETUP;
               end
            end
            SETUP: begin
               io_configs_en <= EN_ONE << io_word_idx;
               state         <= PULSE;
            end
            PULSE: begin
               state <= HOLD;
            end
            HOLD: begin
               if (io_word_idx == LAST_IDX) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  state   <= CHECK;
`else
                  state   <= DONE;
                  io_done <= 1'b1;
`endif
               end else begin
                  io_word_idx <= io_word_idx + 1'b1;
                  state       <= ACCEPT;
               end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            CHECK: begin
               // The checksum word is compared only; it never reaches the latch bus.
               if (io_in_valid) begin
                  error_q <= (io_in_data != xor_acc);
                  io_done <= 1'b1;
                  state   <= DONE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CONFIG_LOADER_CHECKSUM_EN
   assign io_in_ready = (state == ACCEPT) || (state == CHECK);
   assign io_error    = error_q;
`else
   assign io_in_ready = (state == ACCEPT);
   assign io_error    = 1'b0;
`endif

   assign io_busy = (state != IDLE) && (state != DONE);

endmodule
